// File: rtl/sobel_pkg.sv
// Shared types and arithmetic helpers for the streaming sobel pipeline.
package sobel_pkg;

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  // Signed gradient width: four weighted pixel terms per side need three extra bits.
  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  function automatic int abs_i(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int unsigned sat_u(input int unsigned v, input int unsigned w);
    int unsigned lim;
    lim = (32'd1 << w) - 32'd1;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/sobel_stream_if.sv
// Pixel-in / magnitude-out stream bundle; slave is the filter's view.
interface sobel_stream_if #(
  parameter int PIX_W = 8
) ();
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/sobel_line_buf.sv
// Two cascaded row-length delay lines giving the previous two rows at the incoming column.
module sobel_line_buf #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 512
) (
  input  logic             clk,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] tap_r,
  output logic [PIX_W-1:0] tap_rm1
);
  logic [PIX_W-1:0] l1 [IMG_W];
  logic [PIX_W-1:0] l2 [IMG_W];

  // Contents are never cleared; stale data can only land on border outputs.
  always_ff @(posedge clk) begin
    if (en) begin
      l1[0] <= din;
      l2[0] <= l1[IMG_W-1];
      for (int unsigned j = 1; j < IMG_W; j++) begin
        l1[j] <= l1[j-1];
        l2[j] <= l2[j-1];
      end
    end
  end

  assign tap_r   = l1[IMG_W-1];
  assign tap_rm1 = l2[IMG_W-1];
endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 sobel magnitude with zeroed borders, frame-last marking and optional
// odd-column perforation.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512
) (
  input logic            clk,
  input logic            rst_n,
  input logic            cfg_perf,
  sobel_stream_if.slave  bus
);
  localparam int GRAD_W = grad_w(PIX_W);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  state_t state, state_n;
  logic [CW-1:0] in_col, out_col;
  logic [RW-1:0] in_row, out_row;
  logic perf;
  logic room, accept, emit, in_last, out_last, border;
  logic [PIX_W-1:0] tap_r, tap_rm1;
  logic [PIX_W-1:0] colr [3];
  logic [PIX_W-1:0] colc [3];
  logic [PIX_W-1:0] colp [3];
  logic signed [GRAD_W-1:0] wl [3];
  logic signed [GRAD_W-1:0] wm [3];
  logic signed [GRAD_W-1:0] wr [3];
  logic signed [GRAD_W-1:0] gx, gy;
  logic [GRAD_W-1:0] mag;
  logic [PIX_W-1:0] res;

  sobel_line_buf #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb (
    .clk     (clk),
    .en      (accept),
    .din     (bus.s_data),
    .tap_r   (tap_r),
    .tap_rm1 (tap_rm1)
  );

  assign in_last  = (in_row == ROW_MAX) && (in_col == COL_MAX);
  assign out_last = (out_row == ROW_MAX) && (out_col == COL_MAX);
  assign border   = (out_row == '0) || (out_row == ROW_MAX) ||
                    (out_col == '0) || (out_col == COL_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    emit        = 1'b0;
    room        = !bus.m_valid || bus.m_ready;
    bus.s_ready = rst_n && (state != FLUSH) && room;
    accept      = bus.s_valid && bus.s_ready;
    unique case (state)
      FILL:  if (accept && in_row == RW'(1) && in_col == '0) state_n = RUN;
      RUN: begin
        emit = accept;
        if (accept && in_last) state_n = FLUSH;
      end
      FLUSH: begin
        emit = room;
        if (room && out_last) state_n = FILL;
      end
      default: state_n = FILL;
    endcase
  end

  // Incoming pixel forms the right column; two shift stages hold the centre and left columns.
  always_comb begin
    colr[0] = tap_rm1;
    colr[1] = tap_r;
    colr[2] = bus.s_data;
    for (int unsigned j = 0; j < 3; j++) begin
      wl[j] = $signed(GRAD_W'(colp[j]));
      wm[j] = $signed(GRAD_W'(colc[j]));
      wr[j] = $signed(GRAD_W'(colr[j]));
    end
    gx  = (wr[0] + (wr[1] <<< 1) + wr[2]) - (wl[0] + (wl[1] <<< 1) + wl[2]);
    gy  = (wl[0] + (wm[0] <<< 1) + wr[0]) - (wl[2] + (wm[2] <<< 1) + wr[2]);
    mag = GRAD_W'(abs_i(int'(gx)) + abs_i(int'(gy)));
    if (border)                res = '0;
    else if (perf && out_col[0]) res = bus.m_data;
    else                       res = PIX_W'(sat_u(32'(mag), PIX_W));
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      colp <= colc;
      colc <= colr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_col      <= '0;
      in_row      <= '0;
      out_col     <= '0;
      out_row     <= '0;
      perf        <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_last  <= 1'b0;
    end else begin
      if (accept) begin
        if (in_row == '0 && in_col == '0) perf <= cfg_perf;
        if (in_col == COL_MAX) begin
          in_col <= '0;
          in_row <= in_last ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end
      if (emit) begin
        bus.m_valid <= 1'b1;
        bus.m_data  <= res;
        bus.m_last  <= out_last;
        if (out_col == COL_MAX) begin
          out_col <= '0;
          out_row <= out_last ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: 8x6 frames against a direct 2-D sobel model.
module tb_sobel_stream;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
  localparam int P = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_perf = 1'b0;

  sobel_stream_if #(.PIX_W(P)) bus ();

  sobel_stream #(.PIX_W(P), .IMG_W(W), .IMG_H(H)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_perf (cfg_perf),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int d;
    bit last;
  } exp_t;

  exp_t expq[$];
  exp_t e;
  logic [7:0] frame [N];
  int mdl [N];
  int got [N];
  int gota [N];
  int tests = 0;
  int fails = 0;
  int nrx = 0;
  int nlast = 0;
  int nslow = 0;
  bit bp = 1'b0;
  bit stall_prev = 1'b0;
  int held_d, held_l;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic int px(input int r, input int c);
    return int'(frame[r*W + c]);
  endfunction

  task automatic build_model(input bit perf, input int nout);
    for (int k = 0; k < N; k++) begin
      int r, c, gx, gy, m;
      r = k / W;
      c = k % W;
      if (r == 0 || r == H-1 || c == 0 || c == W-1) mdl[k] = 0;
      else if (perf && (c % 2) == 1) mdl[k] = mdl[k-1];
      else begin
        gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
        gy = (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1)) - (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        mdl[k] = (m > 255) ? 255 : m;
      end
    end
    for (int k = 0; k < nout; k++) expq.push_back('{mdl[k], k == N-1});
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", int'(bus.m_valid), 1);
        chk("hold_data", int'(bus.m_data), held_d);
        chk("hold_last", int'(bus.m_last), held_l);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("m_data", int'(bus.m_data), e.d);
          chk("m_last", int'(bus.m_last), int'(e.last));
          if (nrx < N) got[nrx] = int'(bus.m_data);
          nrx++;
          if (bus.m_last) nlast++;
          if (!bus.s_ready) nslow++;
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      held_d = int'(bus.m_data);
      held_l = int'(bus.m_last);
    end
  end

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input int n, input bit gaps, input bit flip);
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          bus.s_valid = 1'b0;
          bus.s_data = 8'($urandom);
          @(posedge clk);
          #1;
        end
      end
      bus.s_valid = 1'b1;
      bus.s_data = frame[i];
      t = 0;
      @(negedge clk);
      while (!bus.s_ready && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 1000) begin
        $display("FAIL s_ready_timeout: got 0, expected 1");
        $fatal(1, "input stalled");
      end
      @(posedge clk);
      #1;
      if (flip && i == 0) cfg_perf = ~cfg_perf;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (expq.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", expq.size(), 0);
    repeat (3) @(negedge clk);
    expq.delete();
  endtask

  task automatic run_frame(input bit perf, input bit gaps, input bit flip);
    cfg_perf = perf;
    nrx = 0;
    nlast = 0;
    nslow = 0;
    build_model(perf, N);
    @(posedge clk);
    #1;
    send(N, gaps, flip);
    drain();
    chk("n_out", nrx, N);
    chk("n_last", nlast, 1);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", int'(bus.s_ready), 0);
    chk("rst_m_valid", int'(bus.m_valid), 0);
    chk("rst_m_data", int'(bus.m_data), 0);
    chk("rst_m_last", int'(bus.m_last), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (frame[i]) frame[i] = 8'd100;
    run_frame(1'b0, 1'b0, 1'b0);
    chk("flat_flush_beats", nslow, 9);
    chk("flat_mid", got[2*W+3], 0);

    foreach (frame[i]) frame[i] = 8'(10 * (i % W));
    run_frame(1'b0, 1'b0, 1'b0);
    chk("ramp_model", mdl[W+1], 80);
    chk("ramp_c3", got[W+3], 80);
    chk("ramp_c6", got[3*W+6], 80);
    chk("ramp_c0", got[2*W], 0);
    chk("ramp_r0", got[3], 0);

    foreach (frame[i]) frame[i] = ((i % W) < 4) ? 8'd0 : 8'd255;
    run_frame(1'b0, 1'b0, 1'b0);
    chk("step_model", mdl[W+4], 255);
    chk("step_c3", got[W+3], 255);
    chk("step_c4", got[2*W+4], 255);
    chk("step_c2", got[W+2], 0);
    chk("step_c5", got[W+5], 0);

    foreach (frame[i]) frame[i] = 8'((i % W) * (i % W));
    run_frame(1'b1, 1'b0, 1'b1);
    chk("perf_model_c3", mdl[2*W+3], 32);
    chk("perf_c1", got[2*W+1], 0);
    chk("perf_c2", got[2*W+2], 32);
    chk("perf_c3", got[2*W+3], 32);
    chk("perf_c4", got[2*W+4], 64);
    chk("perf_c5", got[2*W+5], 64);
    chk("perf_c6", got[2*W+6], 96);
    chk("perf_c7", got[2*W+7], 0);
    run_frame(1'b0, 1'b0, 1'b1);
    chk("noperf_c1", got[2*W+1], 16);
    chk("noperf_c3", got[2*W+3], 48);
    chk("noperf_c6", got[2*W+6], 96);

    foreach (frame[i]) frame[i] = 8'($urandom);
    run_frame(1'b1, 1'b0, 1'b0);
    gota = got;
    bp = 1'b1;
    run_frame(1'b1, 1'b1, 1'b0);
    bp = 1'b0;
    for (int k = 0; k < N; k++) chk("bp_seq", got[k], gota[k]);

    foreach (frame[i]) frame[i] = 8'($urandom);
    cfg_perf = 1'b0;
    nrx = 0;
    nlast = 0;
    build_model(1'b0, 11);
    @(posedge clk);
    #1;
    send(20, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    chk("abort_left", expq.size(), 0);
    chk("abort_n_out", nrx, 11);
    @(negedge clk);
    chk("mid_rst_s_ready", int'(bus.s_ready), 0);
    chk("mid_rst_m_valid", int'(bus.m_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    foreach (frame[i]) frame[i] = 8'd50;
    run_frame(1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
